// File: rtl/upload_packer_pkg.sv
// Shared definitions for the upload packer: FSM encoding, frame constants,
// producer command codes and the header byte selector.
package upload_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_t;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned HDR_LAST_IDX  = 4;
  localparam logic [7:0]  SYNC0_DEFAULT = 8'hAA;
  localparam logic [7:0]  SYNC1_DEFAULT = 8'h44;
  localparam logic [7:0]  OVF_SRC_FLAG  = 8'h80;

  localparam logic [7:0]  CMD_04 = 8'h04;
  localparam logic [7:0]  CMD_05 = 8'h05;
  localparam logic [7:0]  CMD_06 = 8'h06;

  // Header order: SYNC0, SYNC1, source, len high, len low.
  function automatic logic [7:0] hdr_byte(
    input logic [2:0]  idx,
    input logic [7:0]  s0,
    input logic [7:0]  s1,
    input logic [7:0]  src,
    input logic [15:0] len
  );
    case (idx)
      3'd0:    return s0;
      3'd1:    return s1;
      3'd2:    return src;
      3'd3:    return len[15:8];
      default: return len[7:0];
    endcase
  endfunction

endpackage

// File: rtl/upload_packer_buf_ram.sv
// Payload buffer: simple dual-port RAM, one write port, one registered read port.
module upload_buf_ram
  import upload_packer_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [BYTE_W-1:0] o_rdata
);

  logic [BYTE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/upload_packer.sv
// Collects a producer upload block into a buffer, then emits it as a framed
// packet (sync, source, length, payload, checksum) on a valid/ready byte stream.
module upload_packer
  import upload_packer_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 256,
  parameter logic [7:0]  SYNC0     = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1     = SYNC1_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upload_active,
  input  logic       upload_req,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  input  logic       upload_valid,
  output logic       upload_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam int unsigned   AW      = $clog2(BUF_DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  state_t r_state, w_state_nxt;

  logic [CW-1:0] r_count, w_count_nxt;
  logic [CW-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [7:0]    r_src, r_psum;
  logic          r_ovf;
  logic [2:0]    r_hidx;
  logic          r_cs_loaded;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;

  logic          w_rdy, w_accept, w_slot_free, w_load;
  logic [7:0]    w_load_byte, w_src_eff, w_csum, w_rd_data;
  logic [15:0]   w_len;
  logic          w_unused;

  assign w_unused = upload_req;

  upload_buf_ram #(
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (upload_data),
    .i_raddr (w_rd_ptr_nxt[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_rdy       = (r_state == ST_COLLECT) && (r_count < DEPTH_C);
    w_accept    = w_rdy && upload_valid;
    w_count_nxt = r_count + CW'(w_accept);
    w_slot_free = !r_tx_valid || tx_ready;
    w_src_eff   = r_ovf ? (r_src | OVF_SRC_FLAG) : r_src;
    w_len       = 16'(r_count);
    w_csum      = r_psum + w_src_eff + w_len[15:8] + w_len[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The read address is always the next value of r_rd_ptr, so the RAM output
  // already holds buf[r_rd_ptr] whenever PAYLOAD wants to load it.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_byte  = '0;
    w_rd_ptr_nxt = r_rd_ptr;
    unique case (r_state)
      ST_IDLE: begin
        w_rd_ptr_nxt = '0;
        if (upload_active) begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (!upload_active) begin
          w_state_nxt = (w_count_nxt == '0) ? ST_IDLE : ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_byte = hdr_byte(r_hidx, SYNC0, SYNC1, w_src_eff, w_len);
          if (r_hidx == 3'(HDR_LAST_IDX)) begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_byte  = w_rd_data;
          w_rd_ptr_nxt = r_rd_ptr + CW'(1);
          if (r_rd_ptr == r_count - CW'(1)) begin
            w_state_nxt = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (!r_cs_loaded) begin
          if (w_slot_free) begin
            w_load      = 1'b1;
            w_load_byte = w_csum;
          end
        end else if (tx_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_psum      <= '0;
      r_src       <= '0;
      r_ovf       <= 1'b0;
      r_hidx      <= '0;
      r_rd_ptr    <= '0;
      r_cs_loaded <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      if (r_state == ST_IDLE) begin
        r_count     <= '0;
        r_psum      <= '0;
        r_src       <= '0;
        r_ovf       <= 1'b0;
        r_hidx      <= '0;
        r_cs_loaded <= 1'b0;
      end
      if (w_accept) begin
        r_count <= w_count_nxt;
        r_psum  <= r_psum + upload_data;
        if (r_count == '0) begin
          r_src <= upload_source;
        end
      end
      if ((r_state == ST_COLLECT) && upload_valid && !w_rdy) begin
        r_ovf <= 1'b1;
      end
      if ((r_state == ST_HDR) && w_load) begin
        r_hidx <= r_hidx + 3'd1;
      end
      if ((r_state == ST_CSUM) && w_load) begin
        r_cs_loaded <= 1'b1;
      end
      if (w_load) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_load_byte;
      end else if (tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign upload_ready = w_rdy;
  assign tx_data      = r_tx_data;
  assign tx_valid     = r_tx_valid;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_upload_packer.sv
// Self-checking bench for upload_packer: directed frames plus randomized blocks
// checked against a frame model built from the framing rules.
module tb_upload_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       upload_active, upload_req, upload_valid, tx_ready;
  logic [7:0] upload_data, upload_source;
  logic       use_small;

  logic       act_b, act_s, val_b, val_s;
  logic       rdy_b, rdy_s, txv_b, txv_s, busy_b, busy_s;
  logic [7:0] txd_b, txd_s;
  logic       w_upload_ready, w_tx_valid, w_busy;
  logic [7:0] w_tx_data;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rdy_err, stall_err, timeout_err;
  int         cur_depth;

  logic [7:0] in_q[$], in_src[$], exp_q[$], rx_q[$];
  int         rx_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign act_b = upload_active & ~use_small;
  assign val_b = upload_valid  & ~use_small;
  assign act_s = upload_active &  use_small;
  assign val_s = upload_valid  &  use_small;

  upload_packer #(.BUF_DEPTH(256)) u_dut (
    .clk(clk), .rst(rst), .upload_active(act_b), .upload_req(upload_req),
    .upload_data(upload_data), .upload_source(upload_source), .upload_valid(val_b),
    .upload_ready(rdy_b), .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(tx_ready),
    .busy(busy_b)
  );

  upload_packer #(.BUF_DEPTH(4)) u_dut_small (
    .clk(clk), .rst(rst), .upload_active(act_s), .upload_req(upload_req),
    .upload_data(upload_data), .upload_source(upload_source), .upload_valid(val_s),
    .upload_ready(rdy_s), .tx_data(txd_s), .tx_valid(txv_s), .tx_ready(tx_ready),
    .busy(busy_s)
  );

  assign w_upload_ready = use_small ? rdy_s  : rdy_b;
  assign w_tx_valid     = use_small ? txv_s  : txv_b;
  assign w_tx_data      = use_small ? txd_s  : txd_b;
  assign w_busy         = use_small ? busy_s : busy_b;

  // Frame model: keep the first depth bytes, flag overflow in source bit 7,
  // checksum is the byte-wise sum of source, length bytes and payload.
  function automatic void build_exp(input int depth);
    int         n;
    logic [7:0] src, sum;
    n   = (in_q.size() > depth) ? depth : in_q.size();
    src = in_src[0];
    if (in_q.size() > depth) src = src | 8'h80;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h44);
    exp_q.push_back(src);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
    sum = src + n[15:8] + n[7:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(in_q[i]);
      sum = sum + in_q[i];
    end
    exp_q.push_back(sum);
  endfunction

  task automatic drive_block(input int depth, input bit gaps, input bit coincide);
    int n;
    n = in_q.size();
    rdy_err = 0;
    upload_active = 1'b1;
    upload_valid  = 1'b0;
    @(posedge clk); #1;
    if (w_upload_ready !== 1'b1) rdy_err++;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        upload_valid = 1'b0;
        @(posedge clk); #1;
      end
      upload_valid  = 1'b1;
      upload_data   = in_q[i];
      upload_source = in_src[i];
      if (coincide && i == n - 1) upload_active = 1'b0;
      @(posedge clk); #1;
      if (!(coincide && i == n - 1)) begin
        if (w_upload_ready !== ((i + 1 < depth) ? 1'b1 : 1'b0)) rdy_err++;
      end
    end
    upload_valid  = 1'b0;
    upload_active = 1'b0;
  endtask

  // Collects n_exp handshaken bytes; records stall-stability violations.
  task automatic capture(input int n_exp, input bit rand_rdy);
    int         budget;
    bit         stalled;
    logic [7:0] held;
    rx_q.delete();
    rx_cyc.delete();
    budget      = 3000;
    stalled     = 1'b0;
    held        = '0;
    stall_err   = 0;
    timeout_err = 0;
    while (rx_q.size() < n_exp && budget > 0) begin
      if (stalled && !(w_tx_valid === 1'b1 && w_tx_data === held)) stall_err++;
      tx_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (w_tx_valid === 1'b1) begin
        if (tx_ready) begin
          rx_q.push_back(w_tx_data);
          rx_cyc.push_back(cyc);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = w_tx_data;
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) timeout_err = 1;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    use_small     = 1'b0;
    rst           = 1'b1;
    upload_active = 1'b1;
    upload_valid  = 1'b1;
    upload_data   = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (w_upload_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", w_upload_ready); end
    n_checks++; if (w_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", w_tx_valid); end
    n_checks++; if (w_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h expected 00", w_tx_data); end
    n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", w_busy); end
    upload_active = 1'b0;
    upload_valid  = 1'b0;
    rst           = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", w_busy); end
  endtask

  task automatic test_basic();
    use_small = 1'b0;
    in_q   = '{8'h11, 8'h22, 8'h33};
    in_src = '{8'h06, 8'h06, 8'h06};
    exp_q  = '{8'hAA, 8'h44, 8'h06, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6F};
    drive_block(256, 1'b0, 1'b0);
    capture(exp_q.size(), 1'b0);
    n_checks++; if (rdy_err !== 0) begin n_fail++; $display("FAIL basic_ready: got %0d errors expected 0", rdy_err); end
    n_checks++; if (timeout_err !== 0) begin n_fail++; $display("FAIL basic_timeout: got %0d expected 0", timeout_err); end
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte[%0d]: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
    end
    if (rx_cyc.size() == exp_q.size()) begin
      n_checks++;
      if (rx_cyc[rx_cyc.size()-1] - rx_cyc[0] !== exp_q.size() - 1) begin
        n_fail++; $display("FAIL basic_rate: got %0d cycles expected %0d", rx_cyc[rx_cyc.size()-1] - rx_cyc[0], exp_q.size() - 1);
      end
    end
    n_checks++; if (w_busy !== 1'b0 || w_tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b tx_valid=%b expected 0 0", w_busy, w_tx_valid); end
  endtask

  task automatic test_empty();
    int seen;
    use_small     = 1'b0;
    seen          = 0;
    upload_active = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (w_busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy_collect: got %b expected 1", w_busy); end
    @(posedge clk); #1;
    upload_active = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (w_tx_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL empty_tx_valid: got %0d valid cycles expected 0", seen); end
    n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %b expected 0", w_busy); end
  endtask

  task automatic test_overflow();
    use_small = 1'b1;
    in_q   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    in_src = '{8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06};
    exp_q  = '{8'hAA, 8'h44, 8'h86, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h94};
    drive_block(4, 1'b0, 1'b0);
    capture(exp_q.size(), 1'b0);
    n_checks++; if (rdy_err !== 0) begin n_fail++; $display("FAIL ovf_ready: got %0d errors expected 0", rdy_err); end
    n_checks++; if (timeout_err !== 0) begin n_fail++; $display("FAIL ovf_timeout: got %0d expected 0", timeout_err); end
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_byte[%0d]: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
    end
    use_small = 1'b0;
  endtask

  task automatic test_backpressure();
    use_small = 1'b0;
    in_q   = '{8'h5A};
    in_src = '{8'h06};
    exp_q  = '{8'hAA, 8'h44, 8'h06, 8'h00, 8'h01, 8'h5A, 8'h61};
    drive_block(256, 1'b0, 1'b0);
    capture(exp_q.size(), 1'b1);
    n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stall_hold: got %0d violations expected 0", stall_err); end
    n_checks++; if (timeout_err !== 0) begin n_fail++; $display("FAIL bp_timeout: got %0d expected 0", timeout_err); end
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte[%0d]: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    use_small = 1'b0;
    in_q.delete();
    in_src.delete();
    for (int i = 0; i < 10; i++) begin
      in_q.push_back(8'($urandom_range(0, 255)));
      in_src.push_back(8'h05);
    end
    drive_block(256, 1'b0, 1'b0);
    capture(7, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (w_tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_tx_valid: got %b expected 0", w_tx_valid); end
    n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", w_busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    in_q   = '{8'h5A};
    in_src = '{8'h06};
    exp_q  = '{8'hAA, 8'h44, 8'h06, 8'h00, 8'h01, 8'h5A, 8'h61};
    drive_block(256, 1'b0, 1'b0);
    capture(exp_q.size(), 1'b0);
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL midrst_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte[%0d]: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_coincident_fall();
    use_small = 1'b0;
    in_q   = '{8'h10, 8'h20, 8'h30, 8'hF7};
    in_src = '{8'h04, 8'h05, 8'h06, 8'h06};
    build_exp(256);
    drive_block(256, 1'b0, 1'b1);
    capture(exp_q.size(), 1'b0);
    n_checks++; if (timeout_err !== 0) begin n_fail++; $display("FAIL coinc_timeout: got %0d expected 0", timeout_err); end
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL coinc_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL coinc_byte[%0d]: got %02h expected %02h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random(input int iters);
    int  n, depth;
    bit  gaps, coincide, rr;
    for (int it = 0; it < iters; it++) begin
      use_small = ($urandom_range(0, 3) == 0);
      depth     = use_small ? 4 : 256;
      n         = use_small ? $urandom_range(1, 7) : $urandom_range(1, 40);
      gaps      = $urandom_range(0, 1);
      coincide  = $urandom_range(0, 1);
      rr        = $urandom_range(0, 1);
      in_q.delete();
      in_src.delete();
      for (int i = 0; i < n; i++) begin
        in_q.push_back(8'($urandom_range(0, 255)));
        in_src.push_back(i == 0 ? 8'($urandom_range(4, 6)) : 8'($urandom_range(0, 255)));
      end
      build_exp(depth);
      drive_block(depth, gaps, coincide);
      capture(exp_q.size(), rr);
      n_checks++; if (rdy_err !== 0) begin n_fail++; $display("FAIL rand%0d_ready: got %0d errors expected 0", it, rdy_err); end
      n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL rand%0d_stall: got %0d violations expected 0", it, stall_err); end
      n_checks++;
      if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d expected %0d", it, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        n_checks++;
        if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte[%0d]: got %02h expected %02h", it, i, rx_q[i], exp_q[i]); end
      end
      n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_idle: got busy=%b expected 0", it, w_busy); end
      @(posedge clk); #1;
    end
    use_small = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    use_small     = 1'b0;
    upload_active = 1'b0;
    upload_req    = 1'b0;
    upload_valid  = 1'b0;
    upload_data   = '0;
    upload_source = '0;
    tx_ready      = 1'b1;
    cur_depth     = 256;
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_backpressure();
    test_reset_midframe();
    test_coincident_fall();
    test_random(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
